glenn_sipo_rx: RTL

GLENN_SIPO_RX -- requirements
Module: glenn_sipo_rx

---
 rtl/glenn_sipo_rx.sv | 109 ++++++++++
 1 files changed

// File: rtl/glenn_sipo_rx.sv
// Serial-in / parallel-out receiver: LSB-first bits are assembled into a byte and handed off through a one-entry holding register.
// Define GLENN_SIPO_PARITY_EN to add an even-parity bit after each byte and the out_ParityErr flag.
module glenn_sipo_rx (
   input  logic       in_Clk,
   input  logic       in_Rst_n,
   input  logic       in_Serial,
   input  logic       in_BitEn,
   input  logic       in_Start,
   input  logic       in_Ready,
   input  logic       in_ClrOvr,
   output logic [7:0] out_8bitData,
   output logic       out_Valid,
   output logic       out_Overrun,
`ifdef GLENN_SIPO_PARITY_EN
   output logic       out_ParityErr,
`endif
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;

   state_t     state;
   logic [2:0] count;
   logic [7:0] shreg;
   logic [7:0] shifted;
   logic       byte_done;
   logic [7:0] done_byte;
   logic       drop;
`ifdef GLENN_SIPO_PARITY_EN
   logic       done_perr;
`endif

   assign shifted   = {in_Serial, shreg[7:1]};
   assign fsm_state = state;

   // A frame completes on the edge that samples its last bit; a start pulse on that edge wins.
   always_comb begin
      byte_done = 1'b0;
      done_byte = shifted;
`ifdef GLENN_SIPO_PARITY_EN
      done_perr = 1'b0;
      if (!in_Start && in_BitEn && state == PAR) begin
         byte_done = 1'b1;
         done_byte = shreg;
         done_perr = ^{shreg, in_Serial};
      end
`else
      if (!in_Start && in_BitEn && state == DATA && count == 3'd7)
         byte_done = 1'b1;
`endif
   end

   // Handshake: the holding register is offered while out_Valid=1 and is taken on any rising edge where
   // in_Ready=1 too; a byte completing on that same edge refills it, and one completing while it is
   // full and not being taken is dropped and flagged in out_Overrun.
   assign drop = byte_done && out_Valid && !in_Ready;

   always_ff @(posedge in_Clk or negedge in_Rst_n) begin
      if (!in_Rst_n) begin
         state        <= IDLE;
         count        <= 3'd0;
         shreg        <= 8'h00;
         out_8bitData <= 8'h00;
         out_Valid    <= 1'b0;
         out_Overrun  <= 1'b0;
`ifdef GLENN_SIPO_PARITY_EN
         out_ParityErr <= 1'b0;
`endif
      end else begin
         if (in_Start) begin
            state <= DATA;
            count <= in_BitEn ? 3'd1 : 3'd0;
            shreg <= in_BitEn ? {in_Serial, 7'h00} : 8'h00;
         end else if (in_BitEn) begin
            case (state)
               DATA: begin
                  shreg <= shifted;
                  count <= count + 3'd1;
                  if (count == 3'd7) begin
`ifdef GLENN_SIPO_PARITY_EN
                     state <= PAR;
`else
                     state <= IDLE;
`endif
                  end
               end
               PAR:     state <= IDLE;
               default: state <= IDLE;
            endcase
         end

         if (byte_done && !drop) begin
            out_8bitData <= done_byte;
            out_Valid    <= 1'b1;
`ifdef GLENN_SIPO_PARITY_EN
            out_ParityErr <= done_perr;
`endif
         end else if (in_Ready) begin
            out_Valid <= 1'b0;
         end

         if (drop)
            out_Overrun <= 1'b1;
         else if (in_ClrOvr)
            out_Overrun <= 1'b0;
      end
   end

endmodule
